// File: rtl/fc_redundancy_voter.sv
// N-way word-level redundancy voter with skew-bounded capture, fault counting
// and permanent lockout for replicated Ascon cores.
module fc_redundancy_voter #(
  parameter int           N              = 3,
  parameter int           W              = 40,
  parameter int           TW             = 128,
  parameter int           SKEW           = 4,
  parameter int           FAULT_LIMIT    = 8,
  parameter logic [127:0] FAULT_CONSTANT = 128'h8C784
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    rep_ready,
  input  logic [N*W-1:0]  rep_data,
  input  logic [N*TW-1:0] rep_tag,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [TW-1:0]   out_tag,
  output logic            fault_detect,
  output logic [7:0]      fault_count,
  output logic            lockout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_VOTE    = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_LOCK    = 3'd4;

  localparam int CW  = $clog2(SKEW + 2);
  localparam int AW  = $clog2(N + 1);
  localparam int MAJ = (N + 1) / 2;

  localparam logic [W-1:0]  FC_DATA = W'(FAULT_CONSTANT);
  localparam logic [TW-1:0] FC_TAG  = TW'(FAULT_CONSTANT);

  logic [2:0]    state_reg;
  logic [N-1:0]  mask_reg;
  logic [CW-1:0] skew_reg;
  logic [W-1:0]  cap_data_reg [N];
  logic [TW-1:0] cap_tag_reg  [N];
  logic [W-1:0]  win_data_reg;
  logic [TW-1:0] win_tag_reg;
  logic          faulty_reg;
  logic          out_valid_reg;
  logic [W-1:0]  out_data_reg;
  logic [TW-1:0] out_tag_reg;
  logic          fault_detect_reg;
  logic [7:0]    fault_count_reg;
  logic          lockout_reg;

  logic [N-1:0]  new_cap;
  logic [N-1:0]  mask_next;
  logic [CW-1:0] skew_next;
  logic          collect_done;
  logic [7:0]    count_inc;

  assign new_cap   = rep_ready & ~mask_reg;
  assign mask_next = mask_reg | new_cap;
  // The skew window opens on the edge of the first capture, at zero.
  assign skew_next = (mask_reg == '0) ? '0 : skew_reg + 1'b1;
  assign collect_done = (&mask_next) ||
                        ((mask_next != '0) && (skew_next == CW'(SKEW)));
  assign count_inc = (fault_count_reg == 8'hFF) ? 8'hFF : fault_count_reg + 8'd1;

  // Pairwise {text, tag} equality among captured replicas.
  logic [N-1:0]  eq_mat [N];
  logic [AW-1:0] agree  [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_agree
    for (genvar gj = 0; gj < N; gj++) begin : g_pair
      assign eq_mat[gi][gj] = mask_reg[gi] & mask_reg[gj] &
                              (cap_data_reg[gi] == cap_data_reg[gj]) &
                              (cap_tag_reg[gi] == cap_tag_reg[gj]);
    end
    assign agree[gi] = AW'($countones(eq_mat[gi]));
  end

  logic          has_maj;
  logic [W-1:0]  vote_data;
  logic [TW-1:0] vote_tag;
  logic [AW-1:0] win_agree;
  logic          vote_faulty;

  always_comb begin
    has_maj   = 1'b0;
    vote_data = FC_DATA;
    vote_tag  = FC_TAG;
    win_agree = '0;
    for (int i = 0; i < N; i++) begin
      if (!has_maj && (agree[i] >= AW'(MAJ))) begin
        has_maj   = 1'b1;
        vote_data = cap_data_reg[i];
        vote_tag  = cap_tag_reg[i];
        win_agree = agree[i];
      end
    end
    // Anything short of unanimous agreement across all N replicas is a fault.
    vote_faulty = !has_maj || (win_agree != AW'(N));
  end

  always_ff @(posedge clk) begin
    if (state_reg == S_COLLECT) begin
      for (int i = 0; i < N; i++) begin
        if (new_cap[i]) begin
          cap_data_reg[i] <= rep_data[i*W +: W];
          cap_tag_reg[i]  <= rep_tag[i*TW +: TW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= S_IDLE;
      mask_reg         <= '0;
      skew_reg         <= '0;
      win_data_reg     <= '0;
      win_tag_reg      <= '0;
      faulty_reg       <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      out_tag_reg      <= '0;
      fault_detect_reg <= 1'b0;
      fault_count_reg  <= '0;
      lockout_reg      <= 1'b0;
    end else begin
      out_valid_reg    <= 1'b0;
      fault_detect_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            mask_reg  <= '0;
            skew_reg  <= '0;
            state_reg <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          mask_reg <= mask_next;
          skew_reg <= skew_next;
          if (collect_done) state_reg <= S_VOTE;
        end
        S_VOTE: begin
          win_data_reg <= vote_data;
          win_tag_reg  <= vote_tag;
          faulty_reg   <= vote_faulty;
          state_reg    <= S_DONE;
        end
        S_DONE: begin
          out_valid_reg    <= 1'b1;
          out_data_reg     <= win_data_reg;
          out_tag_reg      <= win_tag_reg;
          fault_detect_reg <= faulty_reg;
          state_reg        <= S_IDLE;
          if (faulty_reg) begin
            fault_count_reg <= count_inc;
            if (count_inc >= 8'(FAULT_LIMIT)) begin
              lockout_reg <= 1'b1;
              state_reg   <= S_LOCK;
            end
          end
        end
        S_LOCK: begin
          out_data_reg <= FC_DATA;
          out_tag_reg  <= FC_TAG;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_tag      = out_tag_reg;
  assign fault_detect = fault_detect_reg;
  assign fault_count  = fault_count_reg;
  assign lockout      = lockout_reg;

endmodule

// File: tb/tb_fc_redundancy_voter.sv
// Scoreboard bench for fc_redundancy_voter: directed operations push expected
// results, a negedge monitor pops and compares on every out_valid.
module tb_fc_redundancy_voter;

  localparam int N  = 3;
  localparam int W  = 40;
  localparam int TW = 128;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [N-1:0]    rep_ready = '0;
  logic [N*W-1:0]  rep_data = '0;
  logic [N*TW-1:0] rep_tag = '0;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [TW-1:0]   out_tag;
  logic            fault_detect;
  logic [7:0]      fault_count;
  logic            lockout;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    logic          f;
    logic [7:0]    c;
    logic          l;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   valid_seen = 0;

  always #5 clk = ~clk;

  fc_redundancy_voter #(
    .N(N), .W(W), .TW(TW), .SKEW(4), .FAULT_LIMIT(2),
    .FAULT_CONSTANT(128'h8C784)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rep_ready(rep_ready),
    .rep_data(rep_data), .rep_tag(rep_tag), .out_valid(out_valid),
    .out_data(out_data), .out_tag(out_tag), .fault_detect(fault_detect),
    .fault_count(fault_count), .lockout(lockout)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every out_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      exp_t e;
      valid_seen++;
      $display("OUT t=%0t data=%h tag=%h fault=%b count=%0d lock=%b",
               $time, out_data, out_tag, fault_detect, fault_count, lockout);
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_data", 128'(out_data), 128'(e.d));
        check("out_tag", out_tag, e.t);
        check("fault_detect", 128'(fault_detect), 128'(e.f));
        check("fault_count", 128'(fault_count), 128'(e.c));
        check("lockout", 128'(lockout), 128'(e.l));
      end
    end else if (fault_detect) begin
      check("fault_without_valid", 1, 0);
    end
  end

  task automatic load(input logic [W-1:0] d0, d1, d2, input logic [TW-1:0] t0, t1, t2);
    rep_data = {d2, d1, d0};
    rep_tag  = {t2, t1, t0};
  endtask

  task automatic push(input logic [W-1:0] d, input logic [TW-1:0] t,
                      input logic f, input logic [7:0] c, input logic l);
    exp_t e;
    e.d = d; e.t = t; e.f = f; e.c = c; e.l = l;
    sb.push_back(e);
  endtask

  // Start an operation, present ready on edge T, count edges until out_valid.
  task automatic run_op(input logic [N-1:0] rdy, input int exp_lat, input string name);
    int k;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    rep_ready = rdy;
    @(posedge clk);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        k = i;
        break;
      end
    end
    check({name, "_latency"}, 128'(k), 128'(exp_lat));
    @(negedge clk) rep_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 0);
    check("rst_out_data", 128'(out_data), 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_fault_count", 128'(fault_count), 0);
    check("rst_lockout", 128'(lockout), 0);
    @(negedge clk) rst = 1'b1;

    // Clean unanimous operation.
    load(40'h1122334455, 40'h1122334455, 40'h1122334455, 128'hA5, 128'hA5, 128'hA5);
    push(40'h1122334455, 128'hA5, 1'b0, 8'd0, 1'b0);
    run_op(3'b111, 2, "clean");

    // Replica 1 corrupted, majority still wins.
    load(40'h1122334455, 40'hFF00000000, 40'h1122334455, 128'hA5, 128'hA5, 128'hA5);
    push(40'h1122334455, 128'hA5, 1'b1, 8'd1, 1'b0);
    run_op(3'b111, 2, "one_bad");

    // Reset in COLLECT after a single capture; no output may follow.
    load(40'h0123456789, 40'h0123456789, 40'h0123456789, 128'h11, 128'h11, 128'h11);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    rep_ready = 3'b001;
    @(negedge clk) rep_ready = '0;
    rst = 1'b0;
    #1;
    check("midrst_out_data", 128'(out_data), 0);
    check("midrst_out_tag", out_tag, 0);
    check("midrst_fault_count", 128'(fault_count), 0);
    check("midrst_out_valid", 128'(out_valid), 0);
    @(negedge clk) rst = 1'b1;

    load(40'h0123456789, 40'h0123456789, 40'h0123456789, 128'h11, 128'h11, 128'h11);
    push(40'h0123456789, 128'h11, 1'b0, 8'd0, 1'b0);
    run_op(3'b111, 2, "post_rst");

    // Replica 2 never ready: skew limit ends collection.
    load(40'hCAFEBABE01, 40'hCAFEBABE01, 40'h0000000077, 128'h5A, 128'h5A, 128'h77);
    push(40'hCAFEBABE01, 128'h5A, 1'b1, 8'd1, 1'b0);
    run_op(3'b011, 6, "missing");

    // No majority: constant output, second fault reaches the limit.
    load(40'h1, 40'h2, 40'h4, 128'hA5, 128'hA5, 128'hA5);
    push(40'h8C784, 128'h8C784, 1'b1, 8'd2, 1'b1);
    run_op(3'b111, 2, "no_major");

    repeat (2) @(negedge clk);
    check("lock_out_data", 128'(out_data), 128'h8C784);
    check("lock_out_tag", out_tag, 128'h8C784);
    check("lock_sticky", 128'(lockout), 1);

    v = valid_seen;
    load(40'h1122334455, 40'h1122334455, 40'h1122334455, 128'hA5, 128'hA5, 128'hA5);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    rep_ready = 3'b111;
    repeat (10) @(negedge clk);
    rep_ready = '0;
    check("lock_no_valid", 128'(valid_seen), 128'(v));
    check("lock_data_held", 128'(out_data), 128'h8C784);

    rst = 1'b0;
    #1;
    check("unlock_lockout", 128'(lockout), 0);
    check("unlock_fault_count", 128'(fault_count), 0);
    @(negedge clk) rst = 1'b1;

    repeat (3) @(negedge clk);
    check("sb_empty", 128'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_redundancy_voter.md
Name: fc_redundancy_voter

Overview:
Parametrised N-way redundancy voter and fault monitor for replicated Ascon encryption/decryption cores. It captures each replica's text and tag on its ready, tolerates bounded ready skew, and votes at word level. It flags disagreement, counts faulty operations and enters a permanent lockout after a fault limit. It sits between the N core replicas and the top-level outputs, adding timing, word-level voting and escalation to the fault countermeasure.

Parameters:
N, 3, replica count; odd, 3..7
W, 40, text width per replica (ciphertext or plaintext)
TW, 128, tag width per replica
SKEW, 4, max cycles allowed between first and last replica ready
FAULT_LIMIT, 8, faulty operations before lockout; 1..255
FAULT_CONSTANT, 128'h8C784, substitute value on fault; truncated to W for text, to TW for tag

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  operation start; sampled only in IDLE
rep_ready  in  N  per-replica ready; level or pulse; first rising capture counts
rep_data  in  N*W  replica i text at [i*W +: W]
rep_tag  in  N*TW  replica i tag at [i*TW +: TW]
out_valid  out  1  one-cycle pulse: voted result available
out_data  out  W  voted text; held until next out_valid
out_tag  out  TW  voted tag; held until next out_valid
fault_detect  out  1  one-cycle pulse with out_valid when the operation was faulty
fault_count  out  8  saturating count of faulty operations
lockout  out  1  sticky; set when fault_count reaches FAULT_LIMIT

Behaviour:
- Reset (rst=0, async): state IDLE; out_valid=0, out_data=0, out_tag=0, fault_detect=0, fault_count=0, lockout=0; capture mask and skew counter cleared.
- FSM: IDLE -> COLLECT -> VOTE -> DONE -> IDLE; LOCK is terminal; only reset leaves LOCK.
- IDLE:
  - start=1 clears mask and skew counter, -> COLLECT.
  - start in any other state is ignored.
- COLLECT, per edge:
  - For each i with rep_ready[i]=1 and mask[i]=0: latch rep_data/rep_tag slice i, set mask[i].
  - Skew counter starts at 0 on the edge of the first capture and increments each later edge.
  - Mask full -> VOTE.
  - Skew counter = SKEW with mask not full -> VOTE; missing replicas count as faulty.
  - No ready ever: remains in COLLECT (no timeout before the first capture).
- VOTE, single cycle:
  - Replica i is a candidate if captured.
  - Its agreement = number of captured replicas whose {text, tag} equals replica i's {text, tag}.
  - Some agreement >= (N+1)/2: output that value.
  - Otherwise: output FAULT_CONSTANT.
  - Word-level vote, not bitwise: the output is always a value some replica produced, or the constant.
  - Faulty if any replica is missing, any captured replica disagrees with the winner, or there is no majority.
- DONE, single cycle:
  - out_valid=1; fault_detect=1 if faulty.
  - fault_count increments once, saturating at 255.
  - If the new count >= FAULT_LIMIT: lockout=1, -> LOCK. Otherwise -> IDLE.
- Latency: all ready on the same edge T -> out_valid high in the cycle after edge T+2.
- LOCK:
  - out_data and out_tag forced to FAULT_CONSTANT at entry.
  - out_valid is never asserted again; start, ready and data inputs are ignored.
- Reset mid-operation: returns to IDLE with cleared state; a partial capture is never output.
- out_data/out_tag change only on the DONE edge or at LOCK entry.

Test Plan:
- N=3, all ready same cycle, all data 40'h1122334455, tags 128'hA5 -> out_valid 3 edges later, out_data=40'h1122334455, fault_detect=0, fault_count=0.
- Replica 1 data 40'hFF00000000, others 40'h1122334455 -> out_data=40'h1122334455, fault_detect=1, fault_count=1.
- Three mutually different words, e.g. 40'h1, 40'h2, 40'h4 -> out_data=40'h8C784 (FAULT_CONSTANT truncated to W, not bitwise majority 0), fault_detect=1.
- Replica 2 ready never asserted, SKEW=4 -> VOTE 4 edges after first capture; out_data = agreed value of replicas 0,1; fault_detect=1.
- FAULT_LIMIT=2 with two faulty operations -> lockout=1 after the second out_valid; a third start produces no out_valid; out_data=40'h8C784; only rst=0 clears lockout.
- rst=0 asserted in COLLECT after one capture -> all outputs 0 immediately; a following clean operation votes correctly.
